mips_control_fsm: RTL
=====================

# mips_control_fsm

Parametrised multicycle control FSM for the 16-bit MIPS-style datapath: the next-generation replacement for the fixed-width control unit. It decodes Opcode/funk from the instruction register and sequences the datapath through fetch, decode, execute, memory and write-back states. It adds a memory-ready wait handshake, an explicit conditional-PC-write strobe, and an illegal-instruction trap path. It sits between the IR and every datapath mux/write-enable.

## Interface
- OPW, 4: opcode width (≥4); opcode bits above [3:0] nonzero → illegal
- FW, 3: funk width (≥3); funk bits above [2:0] nonzero → illegal for IO
- TRAP_EN, 1: 1 = illegal instruction enters TRAP; 0 = treated as NOP (DECODE→FETCH)

- CLK  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- Opcode  in  OPW  IR opcode field, stable from DECODE until next FETCH
- funk  in  FW  IR function field (IO select)
- mem_ready  in  1  memory completes access this cycle
- ALUOp  out  2  00 add, 01 sub, 10 R-type funk decode, 11 immediate decode
- SrcA  out  1  0 PC, 1 reg A
- SrcB  out  2  00 reg B, 01 PC increment constant, 10 sign-ext imm, 11 sign-ext imm<<1
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC (link), 11 input port
- RegDest  out  1  0 rt, 1 rd
- RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, OutputWrite, EPCWrite, ExcPC  out  1 each  strobes
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 reg A
- MemSrc  out  1  0 address = PC, 1 = ALUOut
- BranchCond  out  1  0 branch on zero (beq), 1 on not-zero (bne)
- current_state  out  5  state register, debug

## Operation
- Moore outputs from state; unlisted outputs 0. Exception: FETCH IRWrite/PCWrite are gated by mem_ready.
- States (encoding): FETCH 0, DECODE 1, RTYPE_EX 2, RTYPE_WB 3, IMM_EX 4, IMM_WB 5, MEM_ADDR 6, LW_READ 7, LW_WB 8, SW_WRITE 9, BRANCH 10, JUMP 11, JAL 12, JR 13, IN_WB 14, OUT 15, TRAP 16.
- FETCH: MemRead, MemSrc=0, SrcA=0, SrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=mem_ready. Stays in FETCH while !mem_ready; otherwise → DECODE.
- DECODE: SrcA=0, SrcB=11, ALUOp=00 (branch target into ALUOut). Dispatch on Opcode:
  - 0000 → RTYPE_EX; 0001 → IMM_EX; 0010/0011 → MEM_ADDR
  - 0111/1000 → BRANCH; 1001 → JUMP; 1010 → JAL; 1011 → JR
  - 1100 with funk 000 → IN_WB; 1100 with funk 001 → OUT
  - anything else → TRAP (or FETCH if TRAP_EN=0)
- RTYPE_EX: SrcA=1, SrcB=00, ALUOp=10 → RTYPE_WB.
- RTYPE_WB: RegWrite, MemtoReg=00, RegDest=1 → FETCH.
- IMM_EX: SrcA=1, SrcB=10, ALUOp=11 → IMM_WB.
- IMM_WB: RegWrite, MemtoReg=00, RegDest=0 → FETCH.
- MEM_ADDR: SrcA=1, SrcB=10, ALUOp=00 → LW_READ (0010) or SW_WRITE (0011).
- LW_READ: MemRead, MemSrc=1. Holds until mem_ready, then → LW_WB.
- LW_WB: RegWrite, MemtoReg=01, RegDest=0 → FETCH.
- SW_WRITE: MemWrite, MemSrc=1. Holds until mem_ready, then → FETCH.
- BRANCH: SrcA=1, SrcB=00, ALUOp=01, PCWriteCond, PCSrc=01, BranchCond=(Opcode==1000) → FETCH.
- JUMP: PCWrite, PCSrc=10 → FETCH.
- JAL: PCWrite, PCSrc=10, RegWrite, MemtoReg=10, RegDest=1 (ra encoded in rd) → FETCH.
- JR: PCWrite, PCSrc=11 → FETCH.
- IN_WB: RegWrite, MemtoReg=11, RegDest=0 → FETCH.
- OUT: OutputWrite → FETCH.
- TRAP: EPCWrite, ExcPC, PCWrite (datapath loads fixed vector) → FETCH.
- An undefined state encoding (17–31) → FETCH.

## Timing
- Reset high at a rising edge → state=FETCH next cycle. While Reset is high, all strobes (RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, OutputWrite, EPCWrite, ExcPC) are forced 0; mux selects take FETCH values. Reset mid-instruction aborts it with no further strobes.
- Cycle counts with mem_ready=1:
  - R-type, imm, sw: 4
  - lw: 5
  - beq/bne, j, jal, jr, in, out, trap: 3
- Each cycle mem_ready is low in FETCH, LW_READ or SW_WRITE adds exactly one cycle. Outputs are held constant during the wait.
- MemWrite is asserted for the whole SW_WRITE dwell; memory commits on the mem_ready cycle.
- Opcode/funk are sampled only in DECODE and MEM_ADDR.

## Test plan
- Reset=1 for 1 cycle during RTYPE_EX → next cycle current_state=0, no RegWrite pulse; with mem_ready=1, R-type runs 0,1,2,3,0 and RegWrite=1 only in state 3 with RegDest=1.
- lw with mem_ready low for 2 cycles in LW_READ → states 0,1,6,7,7,7,8,0; MemSrc=1 throughout 7; RegWrite with MemtoReg=01 only in 8.
- mem_ready=0 for 3 cycles in FETCH → IRWrite=PCWrite=0 for those cycles, then a single 1-cycle pulse when mem_ready=1.
- beq (0111) → BranchCond=0; bne (1000) → BranchCond=1; PCWriteCond=1 and PCSrc=01 in state 10; PCWrite=0.
- jal (1010) → state 12 asserts PCWrite, RegWrite, MemtoReg=10, PCSrc=10 in the same cycle; in (1100/000) → MemtoReg=11; out (1100/001) → OutputWrite=1 for exactly one cycle.
- Opcode 0100, or 1100 with funk 010 → TRAP_EN=1: state 16 with EPCWrite=ExcPC=PCWrite=1; TRAP_EN=0: DECODE→FETCH with no strobes. OPW=6, Opcode 010000 → illegal.

Source files
------------

// File: rtl/mips_control_fsm_if.sv
// rtl/mips_control_fsm_if.sv - IR/memory inputs and datapath control outputs of the control FSM
interface mips_control_fsm_if #(
    parameter int OPW = 4,
    parameter int FW  = 3
);
    logic [OPW-1:0] Opcode;
    logic [FW-1:0]  funk;
    logic           mem_ready;
    logic [1:0]     ALUOp;
    logic           SrcA;
    logic [1:0]     SrcB;
    logic [1:0]     MemtoReg;
    logic           RegDest;
    logic           RegWrite;
    logic           MemRead;
    logic           MemWrite;
    logic           IRWrite;
    logic           PCWrite;
    logic           PCWriteCond;
    logic           OutputWrite;
    logic           EPCWrite;
    logic           ExcPC;
    logic [1:0]     PCSrc;
    logic           MemSrc;
    logic           BranchCond;
    logic [4:0]     current_state;

    modport master (
        output Opcode, funk, mem_ready,
        input  ALUOp, SrcA, SrcB, MemtoReg, RegDest, RegWrite, MemRead, MemWrite,
               IRWrite, PCWrite, PCWriteCond, OutputWrite, EPCWrite, ExcPC,
               PCSrc, MemSrc, BranchCond, current_state
    );

    modport slave (
        input  Opcode, funk, mem_ready,
        output ALUOp, SrcA, SrcB, MemtoReg, RegDest, RegWrite, MemRead, MemWrite,
               IRWrite, PCWrite, PCWriteCond, OutputWrite, EPCWrite, ExcPC,
               PCSrc, MemSrc, BranchCond, current_state
    );
endinterface

// File: rtl/mips_control_fsm.sv
// rtl/mips_control_fsm.sv - multicycle control FSM for the 16-bit MIPS-style datapath
module mips_control_fsm #(
    parameter int OPW     = 4,
    parameter int FW      = 3,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              Reset,
    mips_control_fsm_if.slave bus
);
    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,  S_DECODE   = 5'd1,  S_RTYPE_EX = 5'd2,  S_RTYPE_WB = 5'd3,
        S_IMM_EX   = 5'd4,  S_IMM_WB   = 5'd5,  S_MEM_ADDR = 5'd6,  S_LW_READ  = 5'd7,
        S_LW_WB    = 5'd8,  S_SW_WRITE = 5'd9,  S_BRANCH   = 5'd10, S_JUMP     = 5'd11,
        S_JAL      = 5'd12, S_JR       = 5'd13, S_IN_WB    = 5'd14, S_OUT      = 5'd15,
        S_TRAP     = 5'd16
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_dispatch;
    logic   r_bne;

    logic [OPW-1:0] w_opcode;
    logic [FW-1:0]  w_funk_full;
    logic [3:0]     w_op;
    logic [2:0]     w_funk;
    logic           w_op_hi_zero;
    logic           w_funk_hi_zero;
    logic           w_illegal;

    assign w_opcode       = bus.Opcode;
    assign w_funk_full    = bus.funk;
    assign w_op           = w_opcode[3:0];
    assign w_funk         = w_funk_full[2:0];
    assign w_op_hi_zero   = (w_opcode >> 4) == '0;
    assign w_funk_hi_zero = (w_funk_full >> 3) == '0;

    // Opcode dispatch out of DECODE; any unrecognised encoding is illegal
    always_comb begin
        w_illegal  = 1'b0;
        w_dispatch = S_FETCH;
        case (w_op)
            4'h0:       w_dispatch = S_RTYPE_EX;
            4'h1:       w_dispatch = S_IMM_EX;
            4'h2, 4'h3: w_dispatch = S_MEM_ADDR;
            4'h7, 4'h8: w_dispatch = S_BRANCH;
            4'h9:       w_dispatch = S_JUMP;
            4'hA:       w_dispatch = S_JAL;
            4'hB:       w_dispatch = S_JR;
            4'hC: begin
                if (w_funk_hi_zero && w_funk == 3'd0)
                    w_dispatch = S_IN_WB;
                else if (w_funk_hi_zero && w_funk == 3'd1)
                    w_dispatch = S_OUT;
                else
                    w_illegal = 1'b1;
            end
            default:    w_illegal = 1'b1;
        endcase
        if (!w_op_hi_zero)
            w_illegal = 1'b1;
        if (w_illegal)
            w_dispatch = TRAP_EN ? S_TRAP : S_FETCH;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = w_dispatch;
            S_RTYPE_EX: w_next = S_RTYPE_WB;
            S_IMM_EX:   w_next = S_IMM_WB;
            S_MEM_ADDR: w_next = (w_op == 4'h3) ? S_SW_WRITE : S_LW_READ;
            S_LW_READ:  w_next = bus.mem_ready ? S_LW_WB : S_LW_READ;
            S_SW_WRITE: w_next = bus.mem_ready ? S_FETCH : S_SW_WRITE;
            default:    w_next = S_FETCH;
        endcase
    end

    // Branch polarity is captured in DECODE so BRANCH does not depend on the live IR
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_FETCH;
            r_bne   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_bne <= (w_op == 4'h8);
        end
    end

    logic [1:0] w_alu_op, w_src_b, w_mem_to_reg, w_pc_src;
    logic       w_src_a, w_reg_dest, w_mem_src, w_br_cond;
    logic       w_reg_write, w_mem_read, w_mem_write, w_ir_write, w_pc_write;
    logic       w_pc_cond, w_out_write, w_epc_write, w_exc_pc;
    state_t     w_out_state;

    // During reset the mux selects show FETCH values and every strobe is held low
    assign w_out_state = Reset ? S_FETCH : r_state;

    always_comb begin
        w_alu_op     = 2'b00;
        w_src_a      = 1'b0;
        w_src_b      = 2'b00;
        w_mem_to_reg = 2'b00;
        w_reg_dest   = 1'b0;
        w_pc_src     = 2'b00;
        w_mem_src    = 1'b0;
        w_br_cond    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_cond    = 1'b0;
        w_out_write  = 1'b0;
        w_epc_write  = 1'b0;
        w_exc_pc     = 1'b0;
        case (w_out_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_src_b    = 2'b01;
                w_ir_write = bus.mem_ready;
                w_pc_write = bus.mem_ready;
            end
            S_DECODE:   w_src_b = 2'b11;
            S_RTYPE_EX: begin
                w_src_a  = 1'b1;
                w_alu_op = 2'b10;
            end
            S_RTYPE_WB: begin
                w_reg_write = 1'b1;
                w_reg_dest  = 1'b1;
            end
            S_IMM_EX: begin
                w_src_a  = 1'b1;
                w_src_b  = 2'b10;
                w_alu_op = 2'b11;
            end
            S_IMM_WB:   w_reg_write = 1'b1;
            S_MEM_ADDR: begin
                w_src_a = 1'b1;
                w_src_b = 2'b10;
            end
            S_LW_READ: begin
                w_mem_read = 1'b1;
                w_mem_src  = 1'b1;
            end
            S_LW_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 2'b01;
            end
            S_SW_WRITE: begin
                w_mem_write = 1'b1;
                w_mem_src   = 1'b1;
            end
            S_BRANCH: begin
                w_src_a   = 1'b1;
                w_alu_op  = 2'b01;
                w_pc_cond = 1'b1;
                w_pc_src  = 2'b01;
                w_br_cond = r_bne;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                w_pc_src   = 2'b10;
            end
            S_JAL: begin
                w_pc_write   = 1'b1;
                w_pc_src     = 2'b10;
                w_reg_write  = 1'b1;
                w_mem_to_reg = 2'b10;
                w_reg_dest   = 1'b1;
            end
            S_JR: begin
                w_pc_write = 1'b1;
                w_pc_src   = 2'b11;
            end
            S_IN_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 2'b11;
            end
            S_OUT:      w_out_write = 1'b1;
            S_TRAP: begin
                w_epc_write = 1'b1;
                w_exc_pc    = 1'b1;
                w_pc_write  = 1'b1;
            end
            default: ;
        endcase
        if (Reset) begin
            w_reg_write = 1'b0;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_ir_write  = 1'b0;
            w_pc_write  = 1'b0;
            w_pc_cond   = 1'b0;
            w_out_write = 1'b0;
            w_epc_write = 1'b0;
            w_exc_pc    = 1'b0;
        end
    end

    assign bus.ALUOp         = w_alu_op;
    assign bus.SrcA          = w_src_a;
    assign bus.SrcB          = w_src_b;
    assign bus.MemtoReg      = w_mem_to_reg;
    assign bus.RegDest       = w_reg_dest;
    assign bus.RegWrite      = w_reg_write;
    assign bus.MemRead       = w_mem_read;
    assign bus.MemWrite      = w_mem_write;
    assign bus.IRWrite       = w_ir_write;
    assign bus.PCWrite       = w_pc_write;
    assign bus.PCWriteCond   = w_pc_cond;
    assign bus.OutputWrite   = w_out_write;
    assign bus.EPCWrite      = w_epc_write;
    assign bus.ExcPC         = w_exc_pc;
    assign bus.PCSrc         = w_pc_src;
    assign bus.MemSrc        = w_mem_src;
    assign bus.BranchCond    = w_br_cond;
    assign bus.current_state = r_state;
endmodule
